// File: rtl/uart_pkg.sv
// Shared defaults, state encoding and the power-up divisor calculation
// for the UART baud-rate generator.
package uart_pkg;

    localparam int DEF_SYS_CLK_FREQ = 200_000_000;
    localparam int DEF_BAUD_RATE    = 19200;
    localparam int DEF_OVERSAMPLE   = 16;
    localparam int DEF_DIV_W        = 16;
    localparam int DEF_FRAC_W       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Rounded fixed-point divisor: sys_clk cycles per oversample tick, scaled by 2^frac_w.
    function automatic longint calc_def_div(input longint sys_clk_freq,
                                            input longint baud_rate,
                                            input longint oversample,
                                            input int     frac_w);
        longint num;
        longint den;
        num = sys_clk_freq << frac_w;
        den = baud_rate * oversample;
        return (2 * num + den) / (2 * den);
    endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Fractional cycle counter: fires every I cycles, or I+1 when the
// fraction accumulator carries.
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    clear,
    input  logic [DIV_W+FRAC_W-1:0] div,
    output logic                    fire
);

    logic [DIV_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac_part;
    logic [DIV_W:0]    cnt_q;
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_sum;
    logic              carry;
    logic [DIV_W:0]    last;

    assign int_part  = div[DIV_W+FRAC_W-1:FRAC_W];
    assign frac_part = div[FRAC_W-1:0];

    // The carry of the pending accumulation stretches the current period by one cycle.
    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, frac_part};
    assign last = {1'b0, int_part} + (DIV_W+1)'(carry) - (DIV_W+1)'(1);
    assign fire = run && !clear && (cnt_q == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (!run || clear) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (cnt_q == last) begin
            cnt_q <= '0;
            acc_q <= acc_sum;
        end else begin
            cnt_q <= cnt_q + (DIV_W+1)'(1);
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: oversample tick, slot index, mid-bit sample and
// bit-boundary strobes, with a shadowed divisor configuration handshake.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ = DEF_SYS_CLK_FREQ,
    parameter int BAUD_RATE    = DEF_BAUD_RATE,
    parameter int OVERSAMPLE   = DEF_OVERSAMPLE,
    parameter int DIV_W        = DEF_DIV_W,
    parameter int FRAC_W       = DEF_FRAC_W
) (
    input  logic                            sys_clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            cfg_valid,
    input  logic [DIV_W+FRAC_W-1:0]         cfg_div,
    output logic                            cfg_ready,
    output logic                            cfg_err,
    input  logic                            rx_resync,
    output logic                            os_tick,
    output logic [$clog2(OVERSAMPLE)-1:0]   os_idx,
    output logic                            rx_sample,
    output logic                            tx_tick
);

    localparam int CFG_W = DIV_W + FRAC_W;
    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam logic [CFG_W-1:0] DEF_DIV =
        CFG_W'(calc_def_div(SYS_CLK_FREQ, BAUD_RATE, OVERSAMPLE, FRAC_W));
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(OVERSAMPLE / 2);

    state_t           state_q;
    state_t           state_d;
    logic             run;
    logic             fire;
    logic [IDX_W-1:0] idx_next;
    logic [CFG_W-1:0] div_q;
    logic [CFG_W-1:0] shadow_q;
    logic             pending_q;
    logic             accept;
    logic             bad_div;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gating with enable keeps the strobes low on the edge that returns to IDLE.
    assign run      = (state_q == RUN) && enable;
    assign idx_next = os_idx + IDX_W'(1);

    uart_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .clk   (sys_clk),
        .rst_n (reset_n),
        .run   (run),
        .clear (rx_resync),
        .div   (div_q),
        .fire  (fire)
    );

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            os_tick   <= 1'b0;
            tx_tick   <= 1'b0;
            rx_sample <= 1'b0;
            os_idx    <= '0;
        end else if (!run || rx_resync) begin
            os_tick   <= 1'b0;
            tx_tick   <= 1'b0;
            rx_sample <= 1'b0;
            os_idx    <= '0;
        end else begin
            os_tick   <= fire;
            tx_tick   <= fire && (idx_next == '0);
            rx_sample <= fire && (idx_next == HALF_IDX);
            if (fire) os_idx <= idx_next;
        end
    end

    assign cfg_ready = (state_q == IDLE) || !pending_q;
    assign accept    = cfg_valid && cfg_ready;
    assign bad_div   = cfg_div[CFG_W-1:FRAC_W] < DIV_W'(2);

    // A divisor accepted while running waits in the shadow until the next tick boundary.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= DEF_DIV;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= accept && bad_div;
            if (state_q == IDLE) begin
                pending_q <= 1'b0;
                if (accept && !bad_div) div_q <= cfg_div;
                else if (pending_q)     div_q <= shadow_q;
            end else if (fire && pending_q) begin
                div_q     <= shadow_q;
                pending_q <= 1'b0;
            end else if (accept && !bad_div) begin
                shadow_q  <= cfg_div;
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: default timing, configuration handshake,
// resynchronisation and asynchronous reset, with hand-computed expectations.
module tb_uart_baud_gen;

    localparam int CFG_W = 20;

    logic             sys_clk   = 1'b0;
    logic             reset_n   = 1'b0;
    logic             enable    = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CFG_W-1:0] cfg_div   = '0;
    logic             rx_resync = 1'b0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             os_tick;
    logic [3:0]       os_idx;
    logic             rx_sample;
    logic             tx_tick;

    int cycle       = 0;
    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [CFG_W-1:0] div;
        logic             expErr;
        int               expFirst;
        int               expSecond;
    } vec_t;

    vec_t vecs[6];

    uart_baud_gen dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .rx_resync (rx_resync),
        .os_tick   (os_tick),
        .os_idx    (os_idx),
        .rx_sample (rx_sample),
        .tx_tick   (tx_tick)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cycle <= cycle + 1;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // which: 0 = os_tick, 1 = tx_tick, 2 = rx_sample; t is the posedge count of the strobe.
    task automatic waitFor(input int which, input int budget, input string name, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if ((which == 0 && os_tick === 1'b1) || (which == 1 && tx_tick === 1'b1) ||
                (which == 2 && rx_sample === 1'b1)) begin
                t = cycle;
                break;
            end
        end
        if (t < 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: no strobe within %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic writeCfg(input logic [CFG_W-1:0] d);
        cfg_valid = 1'b1;
        cfg_div   = d;
        @(negedge sys_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int t0, t1, t2;
        checkOutput($sformatf("vec%0d_ready", idx), cfg_ready, 1);
        writeCfg(v.div);
        checkOutput($sformatf("vec%0d_err", idx), cfg_err, v.expErr);
        cycles(1);
        checkOutput($sformatf("vec%0d_err_clear", idx), cfg_err, 0);
        enable = 1'b1;
        t0 = cycle + 1;
        waitFor(0, 2000, $sformatf("vec%0d_first", idx), t1);
        checkOutput($sformatf("vec%0d_first", idx), t1 - t0, v.expFirst);
        waitFor(0, 2000, $sformatf("vec%0d_second", idx), t2);
        checkOutput($sformatf("vec%0d_second", idx), t2 - t1, v.expSecond);
        enable = 1'b0;
        cycles(2);
        checkOutput($sformatf("vec%0d_idle_idx", idx), os_idx, 0);
        checkOutput($sformatf("vec%0d_idle_tick", idx), os_tick, 0);
    endtask

    initial begin
        int t0, t, prev, tx16, tx32, r, found;

        vecs[0] = '{20'h00010, 1'b1, 651, 651};
        vecs[1] = '{20'h00030, 1'b0, 3, 3};
        vecs[2] = '{20'h00000, 1'b1, 3, 3};
        vecs[3] = '{20'h00058, 1'b0, 5, 6};
        vecs[4] = '{20'h0002F, 1'b0, 2, 3};
        vecs[5] = '{20'h00020, 1'b0, 2, 2};

        cycles(2);
        checkOutput("rst_tick", os_tick, 0);
        checkOutput("rst_tx", tx_tick, 0);
        checkOutput("rst_rx", rx_sample, 0);
        checkOutput("rst_idx", os_idx, 0);
        checkOutput("rst_err", cfg_err, 0);
        checkOutput("rst_ready", cfg_ready, 1);
        reset_n = 1'b1;
        cycles(2);

        // Default divisor 651 + 1/16: fifteen short periods, then one long.
        enable = 1'b1;
        t0   = cycle + 1;
        prev = t0;
        tx16 = 0;
        tx32 = 0;
        for (int j = 1; j <= 32; j++) begin
            waitFor(0, 1000, "def_tick", t);
            checkOutput($sformatf("def_period%0d", j), t - prev, (j % 16 == 0) ? 652 : 651);
            checkOutput($sformatf("def_idx%0d", j), os_idx, j % 16);
            checkOutput($sformatf("def_tx%0d", j), tx_tick, (j % 16 == 0) ? 1 : 0);
            checkOutput($sformatf("def_rx%0d", j), rx_sample, (j % 16 == 8) ? 1 : 0);
            if (j == 16) tx16 = t;
            if (j == 32) tx32 = t;
            prev = t;
        end
        checkOutput("def_tx_period", tx32 - tx16, 10417);
        cycles(1);
        checkOutput("tick_pulse_width", os_tick, 0);

        // Reconfigure while running; a second offer during pending must be ignored.
        cycles(100);
        writeCfg(20'h00040);
        checkOutput("run_cfg_ready_low", cfg_ready, 0);
        checkOutput("run_cfg_err", cfg_err, 0);
        writeCfg(20'h00080);
        checkOutput("ignored_cfg_err", cfg_err, 0);
        checkOutput("ignored_cfg_ready", cfg_ready, 0);
        waitFor(0, 1000, "apply_tick", t);
        checkOutput("apply_old_period", t - tx32, 651);
        checkOutput("apply_cfg_ready", cfg_ready, 1);
        prev = t;
        waitFor(0, 100, "new_period1", t);
        checkOutput("new_period1", t - prev, 4);
        prev = t;
        waitFor(0, 100, "new_period2", t);
        checkOutput("new_period2", t - prev, 4);

        // Resync at os_idx 5 with I=4, F=0.
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            waitFor(0, 100, "find_idx5", t);
            if (os_idx == 4'd5) found = 1;
        end
        checkOutput("found_idx5", found, 1);
        rx_resync = 1'b1;
        r = cycle + 1;
        @(negedge sys_clk);
        rx_resync = 1'b0;
        checkOutput("resync_idx", os_idx, 0);
        waitFor(0, 100, "resync_tick", t);
        checkOutput("resync_latency", t - r, 4);
        checkOutput("resync_idx1", os_idx, 1);
        waitFor(2, 200, "resync_rx", t);
        checkOutput("resync_rx_latency", t - r, 32);
        checkOutput("resync_rx_idx", os_idx, 8);

        // Resync on the very edge a tick would fire suppresses that tick.
        waitFor(0, 100, "coinc_ref", prev);
        cycles(3);
        rx_resync = 1'b1;
        @(negedge sys_clk);
        rx_resync = 1'b0;
        checkOutput("coinc_suppressed", os_tick, 0);
        checkOutput("coinc_idx", os_idx, 0);
        waitFor(0, 100, "coinc_next", t);
        checkOutput("coinc_next_latency", t - (prev + 4), 4);
        checkOutput("coinc_next_idx", os_idx, 1);

        // Asynchronous reset with a pending divisor mid-bit.
        waitFor(0, 100, "rst_ref", t);
        writeCfg(20'h00060);
        checkOutput("pend_ready_low", cfg_ready, 0);
        checkOutput("pend_idx_nonzero", (os_idx != 4'd0) ? 1 : 0, 1);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        checkOutput("async_rst_idx", os_idx, 0);
        checkOutput("async_rst_ready", cfg_ready, 1);
        checkOutput("async_rst_tick", os_tick, 0);
        checkOutput("async_rst_err", cfg_err, 0);
        @(negedge sys_clk);
        reset_n = 1'b1;
        cycles(3);
        checkOutput("post_rst_ready", cfg_ready, 1);
        checkOutput("post_rst_tick", os_tick, 0);
        enable = 1'b1;
        t0 = cycle + 1;
        waitFor(0, 1000, "post_rst_first", t);
        checkOutput("post_rst_first", t - t0, 651);
        prev = t;
        waitFor(0, 1000, "post_rst_second", t);
        checkOutput("post_rst_second", t - prev, 651);
        enable = 1'b0;
        cycles(2);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // Divisor 2.0: tx_tick every 16 * 2 cycles.
        writeCfg(20'h00020);
        enable = 1'b1;
        t0 = cycle + 1;
        waitFor(1, 200, "tx2_first", t);
        checkOutput("tx2_first", t - t0, 32);
        prev = t;
        waitFor(1, 200, "tx2_second", t);
        checkOutput("tx2_period", t - prev, 32);
        enable = 1'b0;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
